// File: rtl/wash_pkg.sv
// Shared types and program lookups for the washing-machine sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_FILL,
    ST_WASH,
    ST_DRAIN,
    ST_SPIN,
    ST_DONE,
    ST_FAULT
  } wash_state_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2,
    PROG_ALT    = 2'd3
  } prog_e;

  // Program code 3 is an alias for normal.
  function automatic int unsigned prog_wash_s(input logic [1:0] prog,
                                              input int unsigned s_quick,
                                              input int unsigned s_normal,
                                              input int unsigned s_heavy);
    case (prog_e'(prog))
      PROG_QUICK: return s_quick;
      PROG_HEAVY: return s_heavy;
      default:    return s_normal;
    endcase
  endfunction

  function automatic logic [1:0] prog_rinses(input logic [1:0] prog);
    case (prog_e'(prog))
      PROG_QUICK: return 2'd1;
      PROG_HEAVY: return 2'd3;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer: counts enabled cycles since the last clear, pulses expire on the last cycle of the limit.
module wash_phase_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 32'd1;
  end

  assign expire = enable && (count == limit - 32'd1);

endmodule

// File: rtl/wash_program_sequencer.sv
// Washing-machine program controller: lock, fill/wash/drain/spin, rinse passes, fault supervision.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | ready, waiting for start with door closed
// LOCK     | door solenoid engaged, one cycle
// FILL     | inlet valve open until full (or timeout)
// WASH     | agitate for main-wash or rinse duration
// DRAIN    | pump until empty (or timeout)
// SPIN     | spin + pump, then next rinse or finish
// DONE     | one-cycle done pulse, door released
// FAULT    | everything off, door locked, reset only
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned WASH_S_QUICK  = 2,
  parameter int unsigned WASH_S_NORMAL = 4,
  parameter int unsigned WASH_S_HEAVY  = 8,
  parameter int unsigned RINSE_S       = 2,
  parameter int unsigned SPIN_S        = 2,
  parameter int unsigned TIMEOUT_S     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] prog,
  input  logic       full,
  input  logic       empty,
  input  logic       cold,
  input  logic       door_closed,
  output logic       ready,
  output logic       door_lock,
  output logic       water_in,
  output logic       wash,
  output logic       drain,
  output logic       spin,
  output logic       heat_r,
  output logic [1:0] rinse_left,
  output logic       done,
  output logic       fault
);

  localparam logic [31:0] TIMEOUT_TICKS = 32'(TIMEOUT_S * TICKS_PER_SEC);
  localparam logic [31:0] RINSE_TICKS   = 32'(RINSE_S * TICKS_PER_SEC);
  localparam logic [31:0] SPIN_TICKS    = 32'(SPIN_S * TICKS_PER_SEC);

  wash_state_e state, state_next;
  logic [1:0]  prog_q;
  logic        main_pass;
  logic        in_phase, door_locked_state, run;
  logic        timer_expire;
  logic [31:0] timer_limit;

  assign in_phase          = (state == ST_FILL) || (state == ST_WASH) ||
                             (state == ST_DRAIN) || (state == ST_SPIN);
  assign door_locked_state = in_phase || (state == ST_LOCK);
  assign run               = in_phase && !pause;

  always_comb begin
    timer_limit = TIMEOUT_TICKS;
    case (state)
      ST_WASH: timer_limit = main_pass
                 ? 32'(prog_wash_s(prog_q, WASH_S_QUICK, WASH_S_NORMAL, WASH_S_HEAVY) * TICKS_PER_SEC)
                 : RINSE_TICKS;
      ST_SPIN: timer_limit = SPIN_TICKS;
      default: timer_limit = TIMEOUT_TICKS;
    endcase
  end

  wash_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (run),
    .limit  (timer_limit),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      prog_q     <= 2'd0;
      rinse_left <= 2'd0;
      main_pass  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && state_next == ST_LOCK) begin
        prog_q     <= prog;
        rinse_left <= prog_rinses(prog);
        main_pass  <= 1'b1;
      end else if (state == ST_SPIN && state_next == ST_FILL) begin
        rinse_left <= rinse_left - 2'd1;
        main_pass  <= 1'b0;
      end
    end
  end

  // Timer expiry only fires while running, so pause already suppresses timed exits.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && door_closed) state_next = ST_LOCK;
      ST_LOCK:  state_next = ST_FILL;
      ST_FILL:  if (run && full)          state_next = ST_WASH;
                else if (timer_expire)    state_next = ST_FAULT;
      ST_WASH:  if (timer_expire)         state_next = ST_DRAIN;
      ST_DRAIN: if (run && empty)         state_next = ST_SPIN;
                else if (timer_expire)    state_next = ST_FAULT;
      ST_SPIN:  if (timer_expire)         state_next = (rinse_left != 2'd0) ? ST_FILL : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
    if (door_locked_state && !door_closed) state_next = ST_FAULT;
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    door_lock = door_locked_state || (state == ST_FAULT);
    water_in  = run && (state == ST_FILL);
    wash      = run && (state == ST_WASH);
    drain     = run && ((state == ST_DRAIN) || (state == ST_SPIN));
    spin      = run && (state == ST_SPIN);
    heat_r    = run && (state == ST_WASH) && main_pass && cold;
    done      = (state == ST_DONE);
    fault     = (state == ST_FAULT);
  end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Self-checking bench for wash_program_sequencer at 10 ticks per second.
module tb_wash_program_sequencer;

  localparam int TPS = 10;

  logic       clk = 1'b0;
  logic       reset, start, pause, full, empty, cold, door_closed;
  logic [1:0] prog;
  logic       ready, door_lock, water_in, wash, drain, spin, heat_r, done, fault;
  logic [1:0] rinse_left;

  wash_program_sequencer #(.TICKS_PER_SEC(TPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .prog        (prog),
    .full        (full),
    .empty       (empty),
    .cold        (cold),
    .door_closed (door_closed),
    .ready       (ready),
    .door_lock   (door_lock),
    .water_in    (water_in),
    .wash        (wash),
    .drain       (drain),
    .spin        (spin),
    .heat_r      (heat_r),
    .rinse_left  (rinse_left),
    .done        (done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  logic [10:0] outs;
  assign outs = {ready, door_lock, water_in, wash, drain, spin, heat_r, rinse_left, done, fault};

  function automatic logic [10:0] mk(input logic rdy, input logic lk, input logic wi, input logic ws,
                                     input logic dr, input logic sp, input logic ht,
                                     input logic [1:0] rl, input logic dn, input logic fl);
    return {rdy, lk, wi, ws, dr, sp, ht, rl, dn, fl};
  endfunction

  logic [10:0] sb_exp[$];
  string       sb_name[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [10:0] mon_e;
  string       mon_n;

  always @(negedge clk) begin
    while (sb_exp.size() != 0) begin
      mon_e = sb_exp.pop_front();
      mon_n = sb_name.pop_front();
      n_vec++;
      if (outs !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (rdy,lk,win,wash,drn,spin,heat,rl[2],done,flt)",
                 mon_n, outs, mon_e);
      end
    end
  end

  task automatic chk(input string nm, input logic [10:0] e);
    sb_exp.push_back(e);
    sb_name.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; full = 1'b0; empty = 1'b0;
    cold = 1'b0; door_closed = 1'b1; prog = 2'd0;
    #2;
    reset = 1'b0;
    step(1);
  endtask

  task automatic start_prog(input logic [1:0] p);
    prog = p; door_closed = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  // Entry: first cycle of FILL. FILL 3 cycles, DRAIN 2 cycles; exit: first cycle after SPIN.
  task automatic do_pass(output int wash_n, output int heat_n, output int spin_n);
    step(2); full = 1'b1; step(1); full = 1'b0;
    wash_n = 0; heat_n = 0;
    while (wash && wash_n < 200) begin
      wash_n++;
      if (heat_r) heat_n++;
      step(1);
    end
    step(1); empty = 1'b1; step(1); empty = 1'b0;
    spin_n = 0;
    while (spin && spin_n < 200) begin
      spin_n++;
      step(1);
    end
  endtask

  typedef struct {
    logic [1:0]  p;
    logic        dc;
    logic        st;
    logic [10:0] e1;
    logic [10:0] e2;
  } vec_t;

  vec_t tbl[6];
  logic [10:0] idle_o;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, s, n, wh, lk_low;
    idle_o = mk(1,0,0,0,0,0,0,2'd0,0,0);
    tbl[0] = '{2'd0, 1'b1, 1'b1, mk(0,1,0,0,0,0,0,2'd1,0,0), mk(0,1,1,0,0,0,0,2'd1,0,0)};
    tbl[1] = '{2'd1, 1'b1, 1'b1, mk(0,1,0,0,0,0,0,2'd2,0,0), mk(0,1,1,0,0,0,0,2'd2,0,0)};
    tbl[2] = '{2'd2, 1'b1, 1'b1, mk(0,1,0,0,0,0,0,2'd3,0,0), mk(0,1,1,0,0,0,0,2'd3,0,0)};
    tbl[3] = '{2'd3, 1'b1, 1'b1, mk(0,1,0,0,0,0,0,2'd2,0,0), mk(0,1,1,0,0,0,0,2'd2,0,0)};
    tbl[4] = '{2'd2, 1'b0, 1'b1, idle_o, idle_o};
    tbl[5] = '{2'd1, 1'b1, 1'b0, idle_o, idle_o};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      chk($sformatf("reset_state_%0d", i), idle_o);
      prog = tbl[i].p; door_closed = tbl[i].dc; start = tbl[i].st;
      step(1);
      chk($sformatf("vec%0d_cycle1", i), tbl[i].e1);
      start = 1'b0;
      step(1);
      chk($sformatf("vec%0d_cycle2", i), tbl[i].e2);
    end

    // Quick program, one rinse pass.
    do_reset();
    start_prog(2'd0);
    chk("p0_fill", mk(0,1,1,0,0,0,0,2'd1,0,0));
    do_pass(w, h, s);
    chk_int("p0_main_wash_cycles", w, 20);
    chk_int("p0_main_spin_cycles", s, 20);
    chk("p0_rinse_fill", mk(0,1,1,0,0,0,0,2'd0,0,0));
    do_pass(w, h, s);
    chk_int("p0_rinse_wash_cycles", w, 20);
    chk("p0_done", mk(0,0,0,0,0,0,0,2'd0,1,0));
    step(1);
    chk("p0_back_idle", idle_o);

    // Heavy program with cold water: heater only in main wash.
    do_reset();
    cold = 1'b1;
    start_prog(2'd2);
    do_pass(w, h, s);
    chk_int("p2_main_wash_cycles", w, 80);
    chk_int("p2_main_heat_cycles", h, 80);
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("p2_rinse%0d_fill", r), mk(0,1,1,0,0,0,0,2'(2 - r),0,0));
      do_pass(w, h, s);
      chk_int($sformatf("p2_rinse%0d_wash", r), w, 20);
      chk_int($sformatf("p2_rinse%0d_heat", r), h, 0);
    end
    chk("p2_done", mk(0,0,0,0,0,0,0,2'd0,1,0));
    cold = 1'b0;

    // Pause 5 cycles in the middle of a 40-cycle main wash.
    do_reset();
    start_prog(2'd1);
    step(2); full = 1'b1; step(1); full = 1'b0;
    n = 0; wh = 0; lk_low = 0;
    while (!drain && n < 300) begin
      pause = (n >= 10 && n < 15);
      #1;
      if (wash) wh++;
      if (!door_lock) lk_low++;
      n++;
      step(1);
    end
    pause = 1'b0;
    chk_int("pause_wash_occupancy", n, 45);
    chk_int("pause_wash_on_cycles", wh, 40);
    chk_int("pause_door_unlocked", lk_low, 0);
    chk("pause_then_drain", mk(0,1,0,0,1,0,0,2'd2,0,0));

    // Asynchronous reset between edges while draining.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_mid_drain", idle_o);
    reset = 1'b0;

    // Fill timeout.
    do_reset();
    start_prog(2'd0);
    n = 0;
    while (water_in && n < 400) begin
      n++;
      step(1);
    end
    chk_int("fill_timeout_cycles", n, 300);
    chk("fill_timeout_fault", mk(0,1,0,0,0,0,0,2'd1,0,1));
    start = 1'b1; full = 1'b1; empty = 1'b1;
    step(5);
    chk("fault_sticky", mk(0,1,0,0,0,0,0,2'd1,0,1));
    do_reset();
    chk("fault_cleared_by_reset", idle_o);

    // Door opened during spin.
    do_reset();
    start_prog(2'd0);
    step(2); full = 1'b1; step(1); full = 1'b0;
    step(20);
    chk("door_test_drain", mk(0,1,0,0,1,0,0,2'd1,0,0));
    step(1); empty = 1'b1; step(1); empty = 1'b0;
    chk("door_test_spin", mk(0,1,0,0,1,1,0,2'd1,0,0));
    step(2);
    door_closed = 1'b0;
    step(1);
    chk("door_open_spin_fault", mk(0,1,0,0,0,0,0,2'd1,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
